// File: rtl/little_alchemy_mouse_tracker.sv
// PS/2 mouse packet tracker: assembles 3-byte packets from the receiver byte stream,
// integrates signed deltas into a clamped absolute cursor position, tracks buttons,
// raises left-button edge pulses and counts discarded bytes / aborted packets.
module little_alchemy_mouse_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [31:0] Mouse_X,
    output logic [31:0] Mouse_Y,
    output logic [2:0]  mouse_buttons,
    output logic        left_press,
    output logic        left_release,
    output logic        packet_valid,
    output logic [7:0]  resync_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    // hdr = {y_overflow, x_overflow, y_sign, x_sign} taken from byte 0
    logic [3:0]      hdr_q, hdr_d;
    logic [2:0]      pend_btn_q, pend_btn_d;
    logic [7:0]      b1_q, b1_d;
    logic [11:0]     x_q, x_d;
    logic [11:0]     y_q, y_d;
    logic [2:0]      btn_q, btn_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            pkt_q, pkt_d;
    logic [7:0]      resync_q, resync_d;

    logic            accept_b0, accept_b1, accept_b2;
    logic            drop, timeout_hit;
    logic signed [11:0] dx, dy, nx, ny;

    // State register and all datapath flops
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= WAIT_B0;
            tmo_q      <= '0;
            hdr_q      <= '0;
            pend_btn_q <= '0;
            b1_q       <= '0;
            x_q        <= 12'(INIT_X);
            y_q        <= 12'(INIT_Y);
            btn_q      <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            pkt_q      <= 1'b0;
            resync_q   <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            hdr_q      <= hdr_d;
            pend_btn_q <= pend_btn_d;
            b1_q       <= b1_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            pkt_q      <= pkt_d;
            resync_q   <= resync_d;
        end
    end

    // Next-state logic: error beats a valid byte, a valid byte beats the timeout
    always_comb begin
        state_d     = state_q;
        accept_b0   = 1'b0;
        accept_b1   = 1'b0;
        accept_b2   = 1'b0;
        drop        = 1'b0;
        timeout_hit = 1'b0;
        if (rx_error) begin
            drop    = 1'b1;
            state_d = WAIT_B0;
        end else begin
            case (state_q)
                WAIT_B0: begin
                    if (rx_valid) begin
                        // bit 3 is always set in a genuine header byte
                        if (rx_byte[3]) begin
                            accept_b0 = 1'b1;
                            state_d   = WAIT_B1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (rx_valid) begin
                        accept_b1 = 1'b1;
                        state_d   = WAIT_B2;
                    end else if (tmo_q == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (rx_valid) begin
                        accept_b2 = 1'b1;
                        state_d   = WAIT_B0;
                    end else if (tmo_q == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = WAIT_B0;
                    end
                end
                default: state_d = WAIT_B0;
            endcase
        end
    end

    // Datapath: byte capture, delta integration with clamping, pulses and counters
    always_comb begin
        hdr_d      = hdr_q;
        pend_btn_d = pend_btn_q;
        b1_d       = b1_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        pkt_d      = 1'b0;
        resync_d   = resync_q;

        // idle counter only runs while a partial packet is pending
        if (state_d == WAIT_B0 || accept_b0 || accept_b1) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (accept_b0) begin
            hdr_d      = rx_byte[7:4];
            pend_btn_d = rx_byte[2:0];
        end
        if (accept_b1) begin
            b1_d = rx_byte;
        end

        // 9-bit deltas sign-extended to 12 bits; overflow flags zero them
        dx = hdr_q[2] ? 12'sd0 : $signed({{4{hdr_q[0]}}, b1_q});
        dy = hdr_q[3] ? 12'sd0 : $signed({{4{hdr_q[1]}}, rx_byte});
        nx = $signed(x_q) + dx;
        // PS/2 +Y points up, screen +Y points down
        ny = $signed(y_q) - dy;

        if (accept_b2) begin
            if (nx[11])          x_d = '0;
            else if (nx > X_MAX) x_d = $unsigned(X_MAX);
            else                 x_d = $unsigned(nx);
            if (ny[11])          y_d = '0;
            else if (ny > Y_MAX) y_d = $unsigned(Y_MAX);
            else                 y_d = $unsigned(ny);
            btn_d     = pend_btn_q;
            press_d   = ~btn_q[0] & pend_btn_q[0];
            release_d = btn_q[0] & ~pend_btn_q[0];
            pkt_d     = 1'b1;
        end

        if ((drop || timeout_hit) && resync_q != 8'hFF) begin
            resync_d = resync_q + 8'd1;
        end
    end

    assign Mouse_X       = {20'd0, x_q};
    assign Mouse_Y       = {20'd0, y_q};
    assign mouse_buttons = btn_q;
    assign left_press    = press_q;
    assign left_release  = release_q;
    assign packet_valid  = pkt_q;
    assign resync_cnt    = resync_q;

endmodule
